uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - Serial receiver paired with the UART transmitter; consumes its serial line and produces parallel bytes.
// - Recovers 8N1-style frames: idle high, start 0, BYTESIZES data bits LSB first, stop 1.
// - Oversamples the line and samples each bit at its centre.
// - Hands bytes to the core on a valid/ready handshake and flags framing and overrun errors.
// PARAMETERS
// - BYTESIZES            8           data bits per frame
// - OVERSAMPLING         16          ticks per bit period (even, >=4)
// - BAUDRATE             115200      line rate, bits/s
// - COUNTER_CLOCK_INPUT  50_000_000  clock frequency, Hz
// PORTS
// - clock      in   1          single clock; all logic rising-edge
// - nreset     in   1          asynchronous, active-low reset
// - rdata      in   1          serial line from transmitter (asynchronous)
// - ready      in   1          consumer accepts byte when valid&&ready
// - data       out  BYTESIZES  received byte, stable while valid
// - valid      out  1          byte available; held until accepted
// - frame_err  out  1          1-cycle pulse: stop bit sampled 0
// - overrun    out  1          1-cycle pulse: byte lost, output still occupied
// - busy       out  1          1 in any state except IDLE
// BEHAVIOUR
// - Reset values:
//   - state=IDLE; data=0; valid=0; frame_err=0; overrun=0; busy=0.
//   - Synchroniser flops=1; tick and sample counters=0.
// - Synchroniser: 2 flops on rdata; rx_s is the second flop. Falling edge = rx_s_prev==1 && rx_s==0.
// - Tick counter:
//   - DIV = COUNTER_CLOCK_INPUT/(BAUDRATE*OVERSAMPLING), integer truncation (27 at defaults).
//   - Counts 0..DIV-1 and pulses tick at DIV-1.
//   - Held at 0 in IDLE; runs in all other states.
// - Sample counter scnt: width $clog2(OVERSAMPLING); increments on tick; cleared on every state change.
// - Bit counter bcnt: width $clog2(BYTESIZES+1).
// - FSM:
//   - IDLE -> START on falling edge.
//   - START: on tick with scnt==OVERSAMPLING/2-1, sample rx_s.
//     - 0 -> DATA, bcnt=0.
//     - 1 -> IDLE (false start, no flag).
//   - DATA: on tick with scnt==OVERSAMPLING-1, shift right and insert rx_s at MSB; bcnt++.
//     - After bit BYTESIZES-1 -> STOP.
//   - STOP: on tick with scnt==OVERSAMPLING-1, sample rx_s.
//     - 1 -> deliver byte, then IDLE.
//     - 0 -> frame_err pulse, byte discarded, then IDLE.
// - Re-arm: IDLE needs a 1->0 edge. A line held low (break) never starts a frame.
// - Deliver:
//   - valid==0: data<=shift, valid<=1 on the next clock (1 cycle after the stop-sample tick).
//   - valid&&ready in the same cycle: old byte consumed, new byte loaded, valid stays 1, no overrun.
//   - valid&&!ready: new byte dropped, data unchanged, overrun pulses 1 cycle.
// - Handshake:
//   - valid falls the cycle after valid&&ready unless a new byte loads that cycle.
//   - data must not change while valid&&!ready.
// - Reset mid-frame: immediately IDLE, no pulses. The partial frame is lost. The next falling edge starts fresh.
// - frame_err and overrun never assert together (a failed frame has no byte to deliver).
// STRUCTURE
// - Package uart_pkg:
//   - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
//   - function calc_div(clk, baud, os) returning the DIV constant.
// - Sub-module uart_rx_tick:
//   - Parameter DIV; inputs clock, nreset, run; output tick.
//   - Counter cleared when run==0.
// - Top holds the synchroniser, FSM, shift register and output register.
// TESTING
// - Defaults (DIV=27, bit=432 clk):
//   - Stimulus: drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), ready=1.
//   - Required: valid 1 cycle, data=8'hA5, no errors.
// - False start:
//   - Stimulus: rdata low for 100 clk, then high.
//   - Required: returns to IDLE, busy drops, valid/frame_err stay 0.
// - Framing error:
//   - Stimulus: frame 0x3C with stop bit 0.
//   - Required: frame_err pulses once, valid stays 0.
//   - Then: the next good frame 0x55 (after line high) gives data=8'h55.
// - Backpressure/overrun:
//   - Stimulus: ready=0, frames 0x11 then 0x22.
//   - Required: data=8'h11 held, overrun pulses once at end of 0x22.
//   - Then: ready=1 gives 0x11 accepted, valid falls.
// - Simultaneous:
//   - Stimulus: 0x11 pending; raise ready on the exact cycle 0x22 completes.
//   - Required: data=8'h22, valid stays 1, overrun=0.
// - Reset mid-frame:
//   - Stimulus: nreset low during bit 4 of 0xF0.
//   - Required: all outputs 0, busy=0.
//   - Then: a full frame 0x0F afterwards gives data=8'h0F.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  // Clocks per oversampling tick; truncating division keeps the tick slightly fast.
  function automatic int calc_div(input int clk, input int baud, input int os);
    return clk / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// rtl/uart_rx_tick.sv - oversampling tick generator, held at zero while not running
module uart_rx_tick #(
  parameter int DIV = 27
) (
  input  logic clock,
  input  logic nreset,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1-style serial receiver with valid/ready byte output
module uart_rx
  import uart_pkg::*;
#(
  parameter int BYTESIZES           = 8,
  parameter int OVERSAMPLING        = 16,
  parameter int BAUDRATE            = 115200,
  parameter int COUNTER_CLOCK_INPUT = 50_000_000
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 rdata,
  input  logic                 ready,
  output logic [BYTESIZES-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = calc_div(COUNTER_CLOCK_INPUT, BAUDRATE, OVERSAMPLING);
  localparam int SW  = $clog2(OVERSAMPLING);
  localparam int BW  = $clog2(BYTESIZES + 1);

  localparam logic [SW-1:0] SMID  = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] SLAST = SW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] BLAST = BW'(BYTESIZES - 1);

  logic                 sync1_q, rx_s_q, rx_prev_q;
  uart_rx_state_t       state_q;
  logic [SW-1:0]        scnt_q;
  logic [BW-1:0]        bcnt_q;
  logic [BYTESIZES-1:0] shift_q;
  logic                 deliver_q, frame_err_q;
  logic [BYTESIZES-1:0] data_q;
  logic                 valid_q, overrun_q;
  logic                 tick, fall;

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clock  (clock),
    .nreset (nreset),
    .run    (state_q != IDLE),
    .tick   (tick)
  );

  // Resetting the synchroniser to 1 makes the idle line look settled after reset.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rdata;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall = rx_prev_q && !rx_s_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (tick) begin
        scnt_q <= scnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            scnt_q  <= '0;
          end
        end
        START: begin
          // Half a bit in: a line already back high was a glitch, not a start bit.
          if (tick && scnt_q == SMID) begin
            scnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
              bcnt_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick && scnt_q == SLAST) begin
            shift_q <= {rx_s_q, shift_q[BYTESIZES-1:1]};
            bcnt_q  <= bcnt_q + 1'b1;
            if (bcnt_q == BLAST) begin
              state_q <= STOP;
              scnt_q  <= '0;
            end
          end
        end
        STOP: begin
          if (tick && scnt_q == SLAST) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            if (rx_s_q) begin
              deliver_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          scnt_q  <= '0;
        end
      endcase
    end
  end

  // A slot freed by ready in the same cycle can take the new byte straight away.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (deliver_q) begin
        if (!valid_q || ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed vector bench for uart_rx at default parameters
module tb_uart_rx;

  localparam int BIT = 432;

  logic       clock = 1'b0;
  logic       nreset, rdata, ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  uart_rx dut (
    .clock     (clock),
    .nreset    (nreset),
    .rdata     (rdata),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         exp_acc;
    int         exp_fe;
  } vec_t;

  vec_t vecs[7];

  int n_cmp = 0;
  int n_fail = 0;
  int acc_cnt = 0, fe_cnt = 0, ov_cnt = 0, both_cnt = 0, vcyc = 0, hold_viol = 0;
  logic [7:0] acc_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;

  always @(negedge clock) begin
    if (nreset) begin
      if (valid && ready) begin
        acc_cnt++;
        acc_data = data;
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (valid) vcyc++;
      if (prev_valid && !prev_ready && valid && data !== prev_data) hold_viol++;
    end
    prev_valid = valid;
    prev_ready = ready;
    prev_data  = data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    acc_cnt   = 0;
    fe_cnt    = 0;
    ov_cnt    = 0;
    vcyc      = 0;
    hold_viol = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clock); #1;
    for (int i = 0; i < 10; i++) begin
      rdata = f[i];
      repeat (BIT) @(posedge clock);
      #1;
    end
    rdata = 1'b1;
  endtask

  initial begin
    logic [9:0] f;
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1};
    vecs[2] = '{8'h55, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 0};
    vecs[5] = '{8'h80, 1'b1, 1, 0};
    vecs[6] = '{8'hFE, 1'b0, 0, 1};

    nreset = 1'b0;
    rdata  = 1'b1;
    ready  = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    nreset = 1'b1;
    repeat (20) @(posedge clock);
    #1;

    for (int i = 0; i < 7; i++) begin
      clear_mon();
      send_frame(vecs[i].b, vecs[i].stop);
      repeat (600) @(posedge clock);
      #1;
      check($sformatf("vec%0d_accepted", i), acc_cnt, vecs[i].exp_acc);
      check($sformatf("vec%0d_valid_cycles", i), vcyc, vecs[i].exp_acc);
      check($sformatf("vec%0d_frame_err", i), fe_cnt, vecs[i].exp_fe);
      check($sformatf("vec%0d_overrun", i), ov_cnt, 0);
      check($sformatf("vec%0d_busy", i), busy, 0);
      if (vecs[i].exp_acc != 0) check($sformatf("vec%0d_data", i), acc_data, vecs[i].b);
    end

    clear_mon();
    @(posedge clock); #1;
    rdata = 1'b0;
    repeat (50) @(posedge clock);
    #1;
    check("false_start_busy_mid", busy, 1);
    repeat (50) @(posedge clock);
    #1;
    rdata = 1'b1;
    repeat (400) @(posedge clock);
    #1;
    check("false_start_busy_end", busy, 0);
    check("false_start_valid", vcyc, 0);
    check("false_start_frame_err", fe_cnt, 0);

    ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1);
    repeat (100) @(posedge clock);
    #1;
    check("bp_first_valid", valid, 1);
    check("bp_first_data", data, 8'h11);
    send_frame(8'h22, 1'b1);
    repeat (100) @(posedge clock);
    #1;
    check("bp_overrun_count", ov_cnt, 1);
    check("bp_held_data", data, 8'h11);
    check("bp_held_valid", valid, 1);
    check("bp_hold_stable", hold_viol, 0);
    check("bp_frame_err", fe_cnt, 0);
    ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("bp_accept_count", acc_cnt, 1);
    check("bp_accept_data", acc_data, 8'h11);
    check("bp_valid_falls", valid, 0);

    ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1);
    repeat (100) @(posedge clock);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (4108) @(posedge clock);
        #1;
        ready = 1'b1;
        @(posedge clock);
        #1;
        ready = 1'b0;
      end
    join
    repeat (100) @(posedge clock);
    #1;
    check("sim_data", data, 8'h22);
    check("sim_valid", valid, 1);
    check("sim_overrun", ov_cnt, 0);
    check("sim_accept_count", acc_cnt, 1);
    check("sim_accept_data", acc_data, 8'h11);
    ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("sim_drain_data", acc_data, 8'h22);
    check("sim_drain_valid", valid, 0);

    clear_mon();
    f = {1'b1, 8'hF0, 1'b0};
    @(posedge clock); #1;
    for (int i = 0; i < 6; i++) begin
      rdata = f[i];
      repeat ((i == 5) ? 200 : BIT) @(posedge clock);
      #1;
    end
    check("rmf_busy_before", busy, 1);
    nreset = 1'b0;
    rdata  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rmf_data", data, 0);
    check("rmf_valid", valid, 0);
    check("rmf_busy", busy, 0);
    check("rmf_frame_err", frame_err, 0);
    check("rmf_overrun", overrun, 0);
    nreset = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    clear_mon();
    send_frame(8'h0F, 1'b1);
    repeat (200) @(posedge clock);
    #1;
    check("rmf_next_count", acc_cnt, 1);
    check("rmf_next_data", acc_data, 8'h0F);
    check("rmf_next_frame_err", fe_cnt, 0);
    check("rmf_next_overrun", ov_cnt, 0);

    check("err_and_overrun_together", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
